// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, copy-engine state type and bus decode helpers
// for the LCD frame buffer slice.
//   LCD_*_BASE      display segment base addresses on the CPU RAM bus
//   LCD_SEG_NIBBLES nibbles per segment (offsets 0x00-0x4F)
//   copy_state_t    live -> shadow copy engine states
//   lcd_bus_hit()   1 when a bus address falls inside either display segment
//   lcd_index()     8-bit RAM index {segment, offset} for a bus address
package lcd_pkg;

    localparam logic [11:0] LCD_LOWER_BASE  = 12'hE00;
    localparam logic [11:0] LCD_UPPER_BASE  = 12'hE80;
    localparam int unsigned LCD_SEG_NIBBLES = 80;
    localparam int unsigned LCD_COLS        = 32;
    localparam int unsigned LCD_ROWS        = 16;
    localparam int unsigned LCD_ICONS       = 8;
    localparam int unsigned LCD_ADDR_W      = 8;
    localparam int unsigned LCD_DATA_W      = 4;

    typedef enum logic [1:0] {
        COPY_IDLE,
        COPY_RUN,
        COPY_DONE
    } copy_state_t;

    // Both segments share addr[11:8]; addr[7] selects lower/upper.
    function automatic logic lcd_bus_hit(input logic [11:0] addr);
        return (addr[11:8] == LCD_LOWER_BASE[11:8]) &&
               (addr[6:0] < 7'(LCD_SEG_NIBBLES));
    endfunction

    function automatic logic [7:0] lcd_index(input logic [11:0] addr);
        return {addr[7], addr[6:0]};
    endfunction

endpackage

// File: rtl/lcd_vram_dp.sv
// lcd_vram_dp: simple dual-port RAM, one write port and one registered read
// port, no reset on contents. Read-during-write to the same address returns
// the old data.
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (sampled every cycle)
//   rd_data  registered read data
module lcd_vram_dp
    import lcd_pkg::*;
#(
    parameter int unsigned ADDR_W = LCD_ADDR_W,
    parameter int unsigned DATA_W = LCD_DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/lcd_frame_buffer.sv
// lcd_frame_buffer: display RAM on the CPU bus with a vblank-triggered
// live -> shadow copy and a pipelined pixel lookup for the LCD renderer.
//   clk, reset_n       clock, synchronous active-low reset
//   bus_addr/_write_*  CPU bus address, write strobe, write nibble
//   bus_hit            previous-cycle address was in a display segment
//   bus_read_data      registered readback nibble (0 when bus_hit=0)
//   display_enable     0 blanks pix_on and icons
//   vblank             rising edge starts a 160-cycle copy
//   pix_req/x/y        pixel lookup request
//   pix_valid/pix_on   lookup result, two cycles after the request
//   icons              icon bits latched at copy completion
//   copy_busy          copy engine running
module lcd_frame_buffer
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] bus_addr,
    input  logic        bus_write_en,
    input  logic [3:0]  bus_write_data,
    output logic        bus_hit,
    output logic [3:0]  bus_read_data,
    input  logic        display_enable,
    input  logic        vblank,
    input  logic        pix_req,
    input  logic [4:0]  pix_x,
    input  logic [3:0]  pix_y,
    output logic        pix_valid,
    output logic        pix_on,
    output logic [7:0]  icons,
    output logic        copy_busy
);

    copy_state_t state, state_next;

    logic       cpu_hit;
    logic [7:0] cpu_idx;
    logic       live_we;
    logic [3:0] cpu_rd_data;
    logic [3:0] copy_rd_data;
    logic [3:0] shadow_rd_data;

    logic [7:0] copy_idx;
    logic       vblank_q;
    logic       shadow_we;
    logic [7:0] shadow_waddr;
    logic [7:0] icon_acc;
    logic [7:0] icons_q;
    logic       frame_ready;

    logic       pix_v1, pix_v2;
    logic [7:0] pix_addr1;
    logic [1:0] pix_bit1, pix_bit2;

    assign cpu_hit = lcd_bus_hit(bus_addr);
    assign cpu_idx = lcd_index(bus_addr);
    assign live_we = bus_write_en && cpu_hit;

    // Live RAM is two copies sharing one write port so the CPU and the copy
    // engine each get a private read port.
    lcd_vram_dp #(.ADDR_W(LCD_ADDR_W), .DATA_W(LCD_DATA_W)) u_live_cpu (
        .clk     (clk),
        .wr_en   (live_we),
        .wr_addr (cpu_idx),
        .wr_data (bus_write_data),
        .rd_addr (cpu_idx),
        .rd_data (cpu_rd_data)
    );

    lcd_vram_dp #(.ADDR_W(LCD_ADDR_W), .DATA_W(LCD_DATA_W)) u_live_copy (
        .clk     (clk),
        .wr_en   (live_we),
        .wr_addr (cpu_idx),
        .wr_data (bus_write_data),
        .rd_addr (copy_idx),
        .rd_data (copy_rd_data)
    );

    lcd_vram_dp #(.ADDR_W(LCD_ADDR_W), .DATA_W(LCD_DATA_W)) u_shadow (
        .clk     (clk),
        .wr_en   (shadow_we),
        .wr_addr (shadow_waddr),
        .wr_data (copy_rd_data),
        .rd_addr (pix_addr1),
        .rd_data (shadow_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_hit <= 1'b0;
        end else begin
            bus_hit <= cpu_hit;
        end
    end

    assign bus_read_data = bus_hit ? cpu_rd_data : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= COPY_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        copy_busy  = 1'b0;
        case (state)
            COPY_IDLE: begin
                if (vblank && !vblank_q) begin
                    state_next = COPY_RUN;
                end
            end
            COPY_RUN: begin
                copy_busy = 1'b1;
                if (copy_idx == 8'hCF) begin
                    state_next = COPY_DONE;
                end
            end
            COPY_DONE: state_next = COPY_IDLE;
            default:   state_next = COPY_IDLE;
        endcase
    end

    // Shadow writes trail the live read by one cycle, so the final upper
    // nibble lands during COPY_DONE; icon nibbles (lower 0x40-0x4E) are
    // captured as they pass and are all present before COPY_DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vblank_q     <= 1'b0;
            copy_idx     <= '0;
            shadow_we    <= 1'b0;
            shadow_waddr <= '0;
            icon_acc     <= '0;
            icons_q      <= '0;
            frame_ready  <= 1'b0;
        end else begin
            vblank_q     <= vblank;
            shadow_we    <= copy_busy;
            shadow_waddr <= copy_idx;
            if (state == COPY_RUN) begin
                copy_idx <= (copy_idx == 8'h4F) ? 8'h80 : copy_idx + 8'd1;
            end else begin
                copy_idx <= '0;
            end
            if (shadow_we && !shadow_waddr[7] &&
                shadow_waddr[6:4] == 3'b100 && !shadow_waddr[0]) begin
                icon_acc[shadow_waddr[3:1]] <= copy_rd_data[0];
            end
            if (state == COPY_DONE) begin
                icons_q     <= icon_acc;
                frame_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_v1 <= 1'b0;
            pix_v2 <= 1'b0;
        end else begin
            pix_v1 <= pix_req;
            pix_v2 <= pix_v1;
        end
    end

    // Shadow index {y[3], 0, x, y[2]}; y[1:0] picks the bit in the nibble.
    always_ff @(posedge clk) begin
        if (pix_req) begin
            pix_addr1 <= {pix_y[3], 1'b0, pix_x, pix_y[2]};
            pix_bit1  <= pix_y[1:0];
        end
        pix_bit2 <= pix_bit1;
    end

    assign pix_valid = pix_v2;
    assign pix_on    = pix_v2 && frame_ready && display_enable &&
                       shadow_rd_data[pix_bit2];
    assign icons     = display_enable ? icons_q : '0;

endmodule

// File: tb/tb_lcd_frame_buffer.sv
// tb_lcd_frame_buffer: scoreboard bench for lcd_frame_buffer. Stimulus tasks
// push hand-computed expectations into queues; one monitor process pops and
// compares whenever the DUT presents a result.
module tb_lcd_frame_buffer;

    logic        clk;
    logic        reset_n;
    logic [11:0] bus_addr;
    logic        bus_write_en;
    logic [3:0]  bus_write_data;
    logic        bus_hit;
    logic [3:0]  bus_read_data;
    logic        display_enable;
    logic        vblank;
    logic        pix_req;
    logic [4:0]  pix_x;
    logic [3:0]  pix_y;
    logic        pix_valid;
    logic        pix_on;
    logic [7:0]  icons;
    logic        copy_busy;

    lcd_frame_buffer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus_addr       (bus_addr),
        .bus_write_en   (bus_write_en),
        .bus_write_data (bus_write_data),
        .bus_hit        (bus_hit),
        .bus_read_data  (bus_read_data),
        .display_enable (display_enable),
        .vblank         (vblank),
        .pix_req        (pix_req),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_valid      (pix_valid),
        .pix_on         (pix_on),
        .icons          (icons),
        .copy_busy      (copy_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic [3:0] data;
    } bus_exp_t;

    typedef struct packed {
        logic       copy_busy;
        logic [7:0] icons;
        logic       bus_hit;
        logic [3:0] bus_read_data;
        logic       pix_valid;
        logic       pix_on;
    } state_t;

    bus_exp_t bus_q[$];
    logic     pix_q[$];
    state_t   st_q[$];
    int       busy_q[$];

    int tests = 0;
    int fails = 0;

    logic bus_chk   = 1'b0;
    logic state_chk = 1'b0;
    logic busy_clr  = 1'b0;
    logic busy_chk  = 1'b0;
    logic fin_chk   = 1'b0;

    // Monitor: sole owner of the pass/fail counters.
    initial begin : monitor
        logic     bus_chk_d;
        int       busy_cnt;
        bus_exp_t be;
        state_t   se;
        state_t   sa;
        logic     pe;
        int       bexp;
        bus_chk_d = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (bus_chk_d) begin
                tests++;
                if (bus_q.size() == 0) begin
                    fails++;
                    $display("FAIL bus_read: result with no expectation queued");
                end else begin
                    be = bus_q.pop_front();
                    if ({bus_hit, bus_read_data} !== be) begin
                        fails++;
                        $display("FAIL bus_read: got hit=%b data=%h, expected hit=%b data=%h",
                                 bus_hit, bus_read_data, be.hit, be.data);
                    end
                end
            end
            bus_chk_d = bus_chk;

            if (pix_valid) begin
                tests++;
                if (pix_q.size() == 0) begin
                    fails++;
                    $display("FAIL pix: unexpected pix_valid");
                end else begin
                    pe = pix_q.pop_front();
                    if (pix_on !== pe) begin
                        fails++;
                        $display("FAIL pix: got pix_on=%b expected %b", pix_on, pe);
                    end
                end
            end

            if (busy_clr) begin
                busy_cnt = 0;
            end else if (copy_busy) begin
                busy_cnt++;
            end

            if (busy_chk) begin
                tests++;
                bexp = (busy_q.size() > 0) ? busy_q.pop_front() : -1;
                if (busy_cnt != bexp) begin
                    fails++;
                    $display("FAIL copy_busy_len: got %0d cycles expected %0d", busy_cnt, bexp);
                end
            end

            if (state_chk) begin
                tests++;
                sa.copy_busy     = copy_busy;
                sa.icons         = icons;
                sa.bus_hit       = bus_hit;
                sa.bus_read_data = bus_read_data;
                sa.pix_valid     = pix_valid;
                sa.pix_on        = pix_on;
                se = (st_q.size() > 0) ? st_q.pop_front() : '1;
                if (sa !== se) begin
                    fails++;
                    $display("FAIL state: got busy=%b icons=%h hit=%b rd=%h pv=%b on=%b, expected busy=%b icons=%h hit=%b rd=%h pv=%b on=%b",
                             sa.copy_busy, sa.icons, sa.bus_hit, sa.bus_read_data, sa.pix_valid, sa.pix_on,
                             se.copy_busy, se.icons, se.bus_hit, se.bus_read_data, se.pix_valid, se.pix_on);
                end
            end

            if (fin_chk) begin
                tests++;
                if (bus_q.size() != 0 || pix_q.size() != 0 || st_q.size() != 0 || busy_q.size() != 0) begin
                    fails++;
                    $display("FAIL drain: got bus=%0d pix=%0d state=%0d busy=%0d pending, expected 0",
                             bus_q.size(), pix_q.size(), st_q.size(), busy_q.size());
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [3:0] d);
        bus_addr       = a;
        bus_write_en   = 1'b1;
        bus_write_data = d;
        step();
        bus_write_en   = 1'b0;
        bus_addr       = 12'h000;
    endtask

    task automatic bus_rd(input logic [11:0] a, input logic eh, input logic [3:0] ed);
        bus_exp_t e;
        e.hit  = eh;
        e.data = ed;
        bus_q.push_back(e);
        bus_addr = a;
        bus_chk  = 1'b1;
        step();
        bus_chk  = 1'b0;
        bus_addr = 12'h000;
    endtask

    task automatic pix(input logic [4:0] x, input logic [3:0] y, input logic e);
        pix_q.push_back(e);
        pix_x   = x;
        pix_y   = y;
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
    endtask

    task automatic pix_drain();
        repeat (3) step();
    endtask

    // Expects an otherwise idle DUT: no bus hit, no pixel result in flight.
    task automatic check_state(input logic busy, input logic [7:0] ic);
        state_t e;
        e.copy_busy     = busy;
        e.icons         = ic;
        e.bus_hit       = 1'b0;
        e.bus_read_data = 4'h0;
        e.pix_valid     = 1'b0;
        e.pix_on        = 1'b0;
        st_q.push_back(e);
        state_chk = 1'b1;
        step();
        state_chk = 1'b0;
    endtask

    task automatic start_copy();
        busy_clr = 1'b1;
        step();
        busy_clr = 1'b0;
        vblank   = 1'b1;
        step();
        vblank   = 1'b0;
    endtask

    task automatic end_copy(input int n_wait, input int exp_cycles);
        repeat (n_wait) step();
        busy_q.push_back(exp_cycles);
        busy_chk = 1'b1;
        step();
        busy_chk = 1'b0;
    endtask

    initial begin : stimulus
        reset_n        = 1'b0;
        bus_addr       = 12'h000;
        bus_write_en   = 1'b0;
        bus_write_data = 4'h0;
        display_enable = 1'b1;
        vblank         = 1'b0;
        pix_req        = 1'b0;
        pix_x          = '0;
        pix_y          = '0;
        repeat (3) step();
        check_state(1'b0, 8'h00);
        reset_n = 1'b1;
        check_state(1'b0, 8'h00);

        // RAM contents are not reset: clear both segments.
        for (int i = 0; i < 80; i++) begin
            bus_wr(12'hE00 + 12'(i), 4'h0);
            bus_wr(12'hE80 + 12'(i), 4'h0);
        end

        // CPU write/readback and segment boundaries.
        bus_wr(12'hE05, 4'hA);
        bus_rd(12'hE05, 1'b1, 4'hA);
        bus_rd(12'hE60, 1'b0, 4'h0);
        bus_rd(12'hED0, 1'b0, 4'h0);
        bus_rd(12'hE4F, 1'b1, 4'h0);
        bus_rd(12'hECF, 1'b1, 4'h0);
        bus_rd(12'hF05, 1'b0, 4'h0);

        bus_wr(12'hE00, 4'hF);
        bus_wr(12'hE81, 4'h8);
        bus_wr(12'hE44, 4'h1);
        bus_rd(12'hE81, 1'b1, 4'h8);

        // No frame copied yet.
        pix(5'd0, 4'd15, 1'b0);
        pix(5'd0, 4'd0, 1'b0);
        pix_drain();

        start_copy();
        end_copy(200, 160);
        check_state(1'b0, 8'b0000_0100);

        pix(5'd0, 4'd0, 1'b1);
        pix(5'd0, 4'd1, 1'b1);
        pix(5'd0, 4'd2, 1'b1);
        pix(5'd0, 4'd3, 1'b1);
        pix(5'd0, 4'd4, 1'b0);
        pix(5'd0, 4'd15, 1'b1);
        pix(5'd0, 4'd14, 1'b0);
        pix(5'd2, 4'd5, 1'b1);
        pix(5'd2, 4'd4, 1'b0);
        pix(5'd2, 4'd7, 1'b1);
        pix_drain();

        display_enable = 1'b0;
        check_state(1'b0, 8'h00);
        pix(5'd0, 4'd0, 1'b0);
        step();
        step();
        display_enable = 1'b1;
        pix_drain();

        // Mid-copy: early write to a not-yet-copied index, vblank re-edge,
        // late write to an already-copied index.
        start_copy();
        repeat (4) step();
        bus_wr(12'hE10, 4'hF);
        repeat (44) step();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        repeat (45) step();
        bus_wr(12'hE00, 4'h0);
        end_copy(120, 160);
        pix(5'd8, 4'd0, 1'b1);
        pix(5'd8, 4'd3, 1'b1);
        pix(5'd0, 4'd0, 1'b1);
        pix_drain();

        start_copy();
        end_copy(200, 160);
        pix(5'd0, 4'd0, 1'b0);
        pix(5'd8, 4'd1, 1'b1);
        pix_drain();

        // Reset part-way through a copy.
        start_copy();
        repeat (79) step();
        reset_n = 1'b0;
        step();
        check_state(1'b0, 8'h00);
        reset_n = 1'b1;
        step();
        pix(5'd0, 4'd15, 1'b0);
        pix_drain();
        check_state(1'b0, 8'h00);

        start_copy();
        end_copy(200, 160);
        pix(5'd0, 4'd15, 1'b1);
        pix(5'd8, 4'd2, 1'b1);
        pix_drain();
        check_state(1'b0, 8'b0000_0100);

        fin_chk = 1'b1;
        step();
        fin_chk = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
